// File: rtl/div_pkg.sv
// Shared definitions for the signed divider.
// Holds the default operand width and the controller state encoding,
// which the top level and the bench both rely on.
package div_pkg;

  // Default operand width in bits
  localparam int DIV_N_DEFAULT = 5;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } state_t;

endpackage

// File: rtl/div_step.sv
// One unsigned restoring shift-subtract iteration.
// Ports:
//   rem_in  [N:0]   current partial remainder
//   bit_in          next dividend bit (MSB first)
//   divisor [N-1:0] divisor magnitude
//   rem_out [N:0]   updated partial remainder
//   q_bit           quotient bit produced by this iteration
module div_step #(
  parameter int N = div_pkg::DIV_N_DEFAULT
) (
  input  logic [N:0]   rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_out,
  output logic         q_bit
);

  // One extra bit above the partial remainder gives the trial subtraction
  // an unambiguous sign bit.
  logic [N+1:0] shifted_s;
  logic [N+1:0] diff_s;

  // Trial subtract; keep the difference only when it did not go negative
  always_comb begin
    shifted_s = {rem_in, bit_in};
    diff_s    = shifted_s - {2'b00, divisor};
    if (diff_s[N+1] == 1'b0) begin
      rem_out = diff_s[N:0];
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted_s[N:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed integer divider (truncating, remainder takes the
// dividend's sign). Fixed latency: done pulses N+2 cycles after start is
// accepted, regardless of operand values.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   start                 begin a division (only honoured when idle)
//   dividend, divisor     signed N-bit operands
//   busy                  operation in progress
//   done                  one-cycle pulse, results valid
//   quotient, remainder   signed N-bit results, held until the next done
//   div_by_zero, overflow status of the last operation
module signed_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] dividend,
  input  logic signed [N-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] quotient,
  output logic signed [N-1:0] remainder,
  output logic                div_by_zero,
  output logic                overflow
);

  localparam int              CW       = $clog2(N + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0]   ONE_CNT  = CW'(1);
  localparam logic [N-1:0]    ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]    ZERO_N   = {N{1'b0}};
  localparam logic [N-1:0]    ALL1_N   = {N{1'b1}};
  localparam logic [N-1:0]    MIN_N    = {1'b1, {(N-1){1'b0}}};

  // Two's complement magnitude; the most-negative value maps to 2^(N-1),
  // which is still representable as an unsigned N-bit number.
  function automatic logic [N-1:0] abs_to_2scomplement(input logic [N-1:0] v);
    logic [N-1:0] m;
    if (v[N-1]) begin
      m = (~v) + ONE_N;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Conditional negate used to re-apply a result sign (zero stays zero).
  function automatic logic [N-1:0] apply_sign(input logic [N-1:0] mag, input logic neg);
    logic [N-1:0] r;
    if (neg) begin
      r = (~mag) + ONE_N;
    end else begin
      r = mag;
    end
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r;
  logic [N:0]      pr_r;        // partial remainder
  logic [N-1:0]    qr_r;        // dividend magnitude shifting out, quotient shifting in
  logic [N-1:0]    dvs_mag_r;
  logic [N-1:0]    dvd_raw_r;   // kept for the divide-by-zero remainder
  logic            sd_r, sv_r;  // dividend / divisor sign bits
  logic            dbz_w_r, ovf_w_r;

  logic            busy_r, done_r, dbz_r, ovf_r;
  logic [N-1:0]    quot_r, rem_r;

  logic [N:0]      pr_next_s;
  logic            qbit_s;
  logic [N-1:0]    fix_q_s, fix_r_s;

  div_step #(.N(N)) u_step (
    .rem_in  (pr_r),
    .bit_in  (qr_r[N-1]),
    .divisor (dvs_mag_r),
    .rem_out (pr_next_s),
    .q_bit   (qbit_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_CNT) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Signed results, with the special cases overriding the iterative answer
  always_comb begin
    fix_q_s = apply_sign(qr_r, sd_r ^ sv_r);
    fix_r_s = apply_sign(pr_r[N-1:0], sd_r);
    if (dbz_w_r) begin
      fix_q_s = ZERO_N;
      fix_r_s = dvd_raw_r;
    end else if (ovf_w_r) begin
      fix_q_s = MIN_N;
      fix_r_s = ZERO_N;
    end else begin
      fix_q_s = fix_q_s;
      fix_r_s = fix_r_s;
    end
  end

  // Datapath: operand capture, iteration, and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= {CW{1'b0}};
      pr_r      <= {(N+1){1'b0}};
      qr_r      <= ZERO_N;
      dvs_mag_r <= ZERO_N;
      dvd_raw_r <= ZERO_N;
      sd_r      <= 1'b0;
      sv_r      <= 1'b0;
      dbz_w_r   <= 1'b0;
      ovf_w_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
      ovf_r     <= 1'b0;
      quot_r    <= ZERO_N;
      rem_r     <= ZERO_N;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (start) begin
            dvd_raw_r <= dividend;
            sd_r      <= dividend[N-1];
            sv_r      <= divisor[N-1];
            qr_r      <= abs_to_2scomplement(dividend);
            dvs_mag_r <= abs_to_2scomplement(divisor);
            dbz_w_r   <= (divisor == ZERO_N);
            ovf_w_r   <= (dividend == MIN_N) && (divisor == ALL1_N);
            pr_r      <= {(N+1){1'b0}};
            cnt_r     <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        CALC: begin
          pr_r  <= pr_next_s;
          qr_r  <= {qr_r[N-2:0], qbit_s};
          cnt_r <= cnt_r + ONE_CNT;
        end
        FIX: begin
          quot_r <= fix_q_s;
          rem_r  <= fix_r_s;
          dbz_r  <= dbz_w_r;
          ovf_r  <= ovf_w_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = $signed(quot_r);
  assign remainder   = $signed(rem_r);
  assign div_by_zero = dbz_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider at N=5: a vector table plus hand-written
// sequences for busy-time interference, back-to-back start and reset abort.
module tb_signed_divider;

  localparam int N   = 5;
  localparam int LAT = N + 2;

  logic                clk = 1'b0;
  logic                rst_n, start;
  logic signed [N-1:0] dividend, divisor;
  logic                busy, done, div_by_zero, overflow;
  logic signed [N-1:0] quotient, remainder;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  signed_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present operands with start, let the next rising edge accept them.
  task automatic launch(input int a, input int b);
    dividend = a[N-1:0];
    divisor  = b[N-1:0];
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  // Count cycles (sampled on falling edges) until done; -1 on timeout.
  task automatic wait_done(output int cyc);
    int  c;
    bit  seen;
    c    = 0;
    seen = 1'b0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      if (done) seen = 1'b1;
    end
    cyc = seen ? c : -1;
  endtask

  // Called in the done cycle: check results, then check the hold cycle.
  task automatic check_result(input string name, input int q, input int r,
                              input int dbz, input int ovf);
    chk({name, "_quot"}, int'(quotient), q);
    chk({name, "_rem"},  int'(remainder), r);
    chk({name, "_dbz"},  int'(div_by_zero), dbz);
    chk({name, "_ovf"},  int'(overflow), ovf);
    chk({name, "_busy_in_done"}, int'(busy), 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, int'(done), 0);
    chk({name, "_quot_hold"}, int'(quotient), q);
    chk({name, "_rem_hold"},  int'(remainder), r);
  endtask

  initial begin
    int c;
    int seen;
    int ndone;

    vecs[0]  = '{ 13,   4,   3,  1, 0, 0};
    vecs[1]  = '{-13,   4,  -3, -1, 0, 0};
    vecs[2]  = '{ 13,  -4,  -3,  1, 0, 0};
    vecs[3]  = '{-13,  -4,   3, -1, 0, 0};
    vecs[4]  = '{  9,   0,   0,  9, 1, 0};
    vecs[5]  = '{-16,  -1, -16,  0, 0, 1};
    vecs[6]  = '{-16,   0,   0, -16, 1, 0};
    vecs[7]  = '{  0,   7,   0,  0, 0, 0};
    vecs[8]  = '{ 15,   1,  15,  0, 0, 0};
    vecs[9]  = '{-16,  15,  -1, -1, 0, 0};
    vecs[10] = '{  7, -16,   0,  7, 0, 0};
    vecs[11] = '{-16,   2,  -8,  0, 0, 0};
    vecs[12] = '{ -7,   7,  -1,  0, 0, 0};
    vecs[13] = '{  5,  -1,  -5,  0, 0, 0};
    vecs[14] = '{ -1,   3,   0, -1, 0, 0};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quot", int'(quotient), 0);
    chk("rst_rem",  int'(remainder), 0);
    chk("rst_dbz",  int'(div_by_zero), 0);
    chk("rst_ovf",  int'(overflow), 0);

    // Release reset and start in the same cycle: the first edge with
    // rst_n high must accept the operation.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(c);
      chk($sformatf("v%0d_latency", i), c, LAT);
      check_result($sformatf("v%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);
    end

    // Operand changes and a start pulse during busy are ignored; a start
    // in the done cycle is accepted straight away.
    launch(13, 4);
    c    = 0;
    seen = 0;
    while (seen == 0 && c < 20) begin
      @(negedge clk);
      c++;
      if (c == 2) begin
        dividend = 5'sd3;
        divisor  = 5'sd1;
        start    = 1'b1;
      end else if (c == 3) begin
        start = 1'b0;
      end
      if (done) seen = 1;
    end
    chk("b2b_first_latency", c, LAT);
    chk("b2b_first_quot", int'(quotient), 3);
    chk("b2b_first_rem",  int'(remainder), 1);
    launch(11, 3);
    wait_done(c);
    chk("b2b_second_latency", c, LAT);
    check_result("b2b_second", 3, 2, 0, 0);

    // Reset in the third CALC cycle aborts the operation.
    launch(13, 4);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quot", int'(quotient), 0);
    chk("abort_rem",  int'(remainder), 0);
    chk("abort_dbz",  int'(div_by_zero), 0);
    chk("abort_ovf",  int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    launch(7, 2);
    wait_done(c);
    chk("after_abort_latency", c, LAT);
    check_result("after_abort", 3, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
